fll_cfg_bridge: RTL and testbench

FLL_CFG_BRIDGE -- requirements
Module: fll_cfg_bridge

---
 rtl/fll_cfg_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_fll_cfg_bridge.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_bridge.sv
// Purpose : APB slave bridging configuration accesses onto three FLL request/ack ports plus a lock-status register.
// Latency : FLL access = 1 IDLE cycle + REQ cycles until ack (or timeout) + 1 DONE cycle; status access is zero-wait.
// Backpr. : pready_o is held low while an FLL transfer is pending; new transfers are accepted only in IDLE.
//
// Ports:
//   clk_i, rst_ni                    - clock (rising edge) and asynchronous active-low reset
//   paddr_i/pwdata_i/pwrite_i/psel_i/penable_i, prdata_o/pready_o/pslverr_o - APB slave
//   <x>_fll_req_o/_wrn_o/_add_o/_data_o - request side towards FLL x (x = soc, per, cluster)
//   <x>_fll_ack_i/_r_data_i/_lock_i     - response side and asynchronous lock flag from FLL x
module fll_cfg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,

    output logic                      soc_fll_req_o,
    output logic                      soc_fll_wrn_o,
    output logic [1:0]                soc_fll_add_o,
    output logic [31:0]               soc_fll_data_o,
    input  logic                      soc_fll_ack_i,
    input  logic [31:0]               soc_fll_r_data_i,
    input  logic                      soc_fll_lock_i,

    output logic                      per_fll_req_o,
    output logic                      per_fll_wrn_o,
    output logic [1:0]                per_fll_add_o,
    output logic [31:0]               per_fll_data_o,
    input  logic                      per_fll_ack_i,
    input  logic [31:0]               per_fll_r_data_i,
    input  logic                      per_fll_lock_i,

    output logic                      cluster_fll_req_o,
    output logic                      cluster_fll_wrn_o,
    output logic [1:0]                cluster_fll_add_o,
    output logic [31:0]               cluster_fll_data_o,
    input  logic                      cluster_fll_ack_i,
    input  logic [31:0]               cluster_fll_r_data_i,
    input  logic                      cluster_fll_lock_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0]  TGT_SOC = 2'd0;
    localparam logic [1:0]  TGT_PER = 2'd1;
    localparam logic [1:0]  TGT_CLU = 2'd2;
    localparam logic [1:0]  TGT_STS = 2'd3;
    // Last REQ cycle index before giving up on the ack.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [1:0]  add_q, add_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wrn_q, wrn_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  lock_meta_q, lock_meta_d;
    logic [2:0]  lock_sync_q, lock_sync_d;

    logic        apb_acc;
    logic [1:0]  addr_tgt;
    logic        sts_acc;
    logic        sel_ack;
    logic [31:0] sel_rdata;

    // Only the target/register fields of the address are decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{paddr_i[APB_ADDR_WIDTH-1:6], paddr_i[1:0]};

    assign apb_acc  = psel_i & penable_i;
    assign addr_tgt = paddr_i[5:4];
    assign sts_acc  = apb_acc & (addr_tgt == TGT_STS) & (state_q == ST_IDLE);

    // Response of the FLL currently being addressed; other FLLs' acks never reach the FSM.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = 32'h0;
        case (tgt_q)
            TGT_SOC: begin sel_ack = soc_fll_ack_i;     sel_rdata = soc_fll_r_data_i;     end
            TGT_PER: begin sel_ack = per_fll_ack_i;     sel_rdata = per_fll_r_data_i;     end
            TGT_CLU: begin sel_ack = cluster_fll_ack_i; sel_rdata = cluster_fll_r_data_i; end
            default: begin sel_ack = 1'b0;              sel_rdata = 32'h0;                end
        endcase
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        add_d       = add_q;
        wdata_d     = wdata_q;
        wrn_d       = wrn_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        lock_meta_d = {cluster_fll_lock_i, per_fll_lock_i, soc_fll_lock_i};
        lock_sync_d = lock_meta_q;

        case (state_q)
            ST_IDLE: begin
                if (apb_acc && (addr_tgt != TGT_STS)) begin
                    tgt_d   = addr_tgt;
                    add_d   = paddr_i[3:2];
                    wdata_d = pwdata_i;
                    wrn_d   = ~pwrite_i;
                    cnt_d   = 16'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (sel_ack) begin
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_SOC;
            add_q       <= 2'd0;
            wdata_q     <= 32'h0;
            wrn_q       <= 1'b1;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
            lock_meta_q <= 3'b000;
            lock_sync_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            add_q       <= add_d;
            wdata_q     <= wdata_d;
            wrn_q       <= wrn_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    // APB response: DONE completes an FLL transfer, status accesses complete in their first access cycle.
    always_comb begin
        pready_o  = 1'b0;
        prdata_o  = 32'h0;
        pslverr_o = 1'b0;
        if (state_q == ST_DONE) begin
            pready_o  = 1'b1;
            prdata_o  = rdata_q;
            pslverr_o = err_q;
        end else if (sts_acc) begin
            pready_o = 1'b1;
            if (pwrite_i) begin
                pslverr_o = 1'b1;
            end else begin
                prdata_o = {29'h0, lock_sync_q};
            end
        end
    end

    // Requests decode straight from the state flop so a reset drops them asynchronously.
    assign soc_fll_req_o      = (state_q == ST_REQ) && (tgt_q == TGT_SOC);
    assign per_fll_req_o      = (state_q == ST_REQ) && (tgt_q == TGT_PER);
    assign cluster_fll_req_o  = (state_q == ST_REQ) && (tgt_q == TGT_CLU);

    assign soc_fll_wrn_o      = wrn_q;
    assign per_fll_wrn_o      = wrn_q;
    assign cluster_fll_wrn_o  = wrn_q;
    assign soc_fll_add_o      = add_q;
    assign per_fll_add_o      = add_q;
    assign cluster_fll_add_o  = add_q;
    assign soc_fll_data_o     = wdata_q;
    assign per_fll_data_o     = wdata_q;
    assign cluster_fll_data_o = wdata_q;

endmodule

// File: tb/tb_fll_cfg_bridge.sv
// Purpose : self-checking bench for fll_cfg_bridge with a transaction-level model and per-cycle compare.
// Latency : model predicts REQ length, completion cycle, data and error for every APB transfer.
// Backpr. : the APB master holds the access phase until the model's completion cycle.
module tb_fll_cfg_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite, psel, penable;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;

    logic [2:0]  req_w, wrn_w, ack_v, lock_v;
    logic [1:0]  add_w  [3];
    logic [31:0] data_w [3];
    logic [31:0] rdat   [3];

    // expectations for the current cycle, written by the stimulus process
    bit          exp_chk, exp_rst_chk, exp_fll_chk, exp_pready, exp_pslverr, exp_wrn;
    logic [2:0]  exp_req;
    logic [31:0] exp_prdata, exp_data;
    logic [1:0]  exp_add, exp_tgt;
    int          acc_cycle;

    // hand-computed expectations for directed transfers
    bit          lit_on;
    int          lit_tgt, lit_cycle, lit_req_len;
    logic [31:0] lit_prdata, lit_data;
    bit          lit_pslverr, lit_wrn;
    logic [1:0]  lit_add;

    // lock history: [0] driven this cycle, [2] driven two cycles ago
    logic [2:0]  hist [3];
    bit          noise_en, lock_rand_en;
    logic [2:0]  tgt_mask;

    int errors = 0;
    int checks = 0;
    int req_run = 0;

    always #5 clk = ~clk;

    fll_cfg_bridge #(.TIMEOUT_CYCLES(T), .APB_ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel), .penable_i(penable),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .soc_fll_req_o(req_w[0]), .soc_fll_wrn_o(wrn_w[0]), .soc_fll_add_o(add_w[0]),
        .soc_fll_data_o(data_w[0]), .soc_fll_ack_i(ack_v[0]), .soc_fll_r_data_i(rdat[0]),
        .soc_fll_lock_i(lock_v[0]),
        .per_fll_req_o(req_w[1]), .per_fll_wrn_o(wrn_w[1]), .per_fll_add_o(add_w[1]),
        .per_fll_data_o(data_w[1]), .per_fll_ack_i(ack_v[1]), .per_fll_r_data_i(rdat[1]),
        .per_fll_lock_i(lock_v[1]),
        .cluster_fll_req_o(req_w[2]), .cluster_fll_wrn_o(wrn_w[2]), .cluster_fll_add_o(add_w[2]),
        .cluster_fll_data_o(data_w[2]), .cluster_fll_ack_i(ack_v[2]), .cluster_fll_r_data_i(rdat[2]),
        .cluster_fll_lock_i(lock_v[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // single compare process, sampling away from the active edge
    always @(negedge clk) begin
        if (exp_chk) begin
            chk("req", {29'h0, req_w}, {29'h0, exp_req});
            chk("pready", {31'h0, pready_o}, {31'h0, exp_pready});
            chk("prdata", prdata_o, exp_prdata);
            chk("pslverr", {31'h0, pslverr_o}, {31'h0, exp_pslverr});
            if (exp_fll_chk) begin
                chk("fll_wrn", {31'h0, wrn_w[int'(exp_tgt)]}, {31'h0, exp_wrn});
                chk("fll_add", {30'h0, add_w[int'(exp_tgt)]}, {30'h0, exp_add});
                chk("fll_data", data_w[int'(exp_tgt)], exp_data);
            end
            if (exp_rst_chk) begin
                chk("rst_wrn", {29'h0, wrn_w}, 32'h7);
                chk("rst_add", {26'h0, add_w[2], add_w[1], add_w[0]}, 32'h0);
                chk("rst_data", data_w[0] | data_w[1] | data_w[2], 32'h0);
            end
            if (acc_cycle == 0) req_run = 0;
            else if (lit_on && req_w[lit_tgt]) req_run++;
            if (lit_on && exp_fll_chk) begin
                chk("lit_add", {30'h0, add_w[lit_tgt]}, {30'h0, lit_add});
                chk("lit_wrn", {31'h0, wrn_w[lit_tgt]}, {31'h0, lit_wrn});
                chk("lit_data", data_w[lit_tgt], lit_data);
            end
            if (lit_on && exp_pready) begin
                chk("lit_cycle", acc_cycle, lit_cycle);
                chk("lit_ready", {31'h0, pready_o}, 32'h1);
                chk("lit_prdata", prdata_o, lit_prdata);
                chk("lit_pslverr", {31'h0, pslverr_o}, {31'h0, lit_pslverr});
                chk("lit_req_len", req_run, lit_req_len);
            end
        end
    end

    task automatic set_idle_exp();
        exp_req = 3'b000; exp_pready = 0; exp_prdata = 32'h0; exp_pslverr = 0;
        exp_fll_chk = 0; acc_cycle = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (lock_rand_en && $urandom_range(0, 5) == 0) lock_v = 3'($urandom);
        hist[0] = lock_v;
        ack_v = noise_en ? (3'($urandom) & ~tgt_mask) : 3'b000;
    endtask

    task automatic set_lit(input int tg, input int cyc, input logic [31:0] prd, input bit err,
                           input int len, input logic [1:0] ad, input bit wn, input logic [31:0] dat);
        lit_tgt = tg; lit_cycle = cyc; lit_prdata = prd; lit_pslverr = err;
        lit_req_len = len; lit_add = ad; lit_wrn = wn; lit_data = dat; lit_on = 1;
    endtask

    // One APB transfer; d = cycles from req rising to ack (d < 0: the FLL never acks).
    task automatic do_xfer(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                           input logic [31:0] rdv, input int d);
        logic [1:0]  tgt;
        int          n, r;
        bit          err;
        logic [31:0] prd;
        tgt = a[5:4];
        exp_rst_chk = 0;
        tgt_mask = (tgt == 2'd3) ? 3'b000 : (3'b001 << tgt);
        for (int i = 0; i < 3; i++) rdat[i] = $urandom;
        if (tgt != 2'd3) rdat[int'(tgt)] = rdv;
        if (tgt == 2'd3) begin
            n = 0; err = wr; prd = 32'h0; r = 1;
        end else begin
            if (d >= 0 && d + 1 <= T) begin n = d + 1; err = 0; prd = rdv; end
            else begin n = T; err = 1; prd = 32'h0; end
            r = n + 2;
        end
        tick();
        paddr = a; pwdata = wd; pwrite = wr; psel = 1; penable = 0;
        set_idle_exp();
        for (int k = 1; k <= r; k++) begin
            tick();
            penable = 1;
            if (tgt != 2'd3 && d >= 0 && k == d + 2) ack_v[int'(tgt)] = 1'b1;
            acc_cycle = k;
            exp_req = (tgt != 2'd3 && k >= 2 && k <= n + 1) ? (3'b001 << tgt) : 3'b000;
            exp_fll_chk = (exp_req != 3'b000);
            exp_tgt = tgt; exp_wrn = ~wr; exp_add = a[3:2]; exp_data = wd;
            exp_pready = (k == r);
            if (k == r) begin
                exp_prdata  = (tgt == 2'd3) ? (wr ? 32'h0 : {29'h0, hist[2]}) : prd;
                exp_pslverr = err;
            end else begin
                exp_prdata  = 32'h0;
                exp_pslverr = 0;
            end
        end
        tick();
        psel = 0; penable = 0;
        set_idle_exp();
    endtask

    initial begin
        rst_ni = 0; psel = 0; penable = 0; pwrite = 0; paddr = 12'h0; pwdata = 32'h0;
        ack_v = 3'b000; lock_v = 3'b000; tgt_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin rdat[i] = 32'h0; hist[i] = 3'b000; end
        noise_en = 0; lock_rand_en = 0; lit_on = 0;
        set_idle_exp();
        exp_rst_chk = 1; exp_chk = 1;
        repeat (3) tick();
        rst_ni = 1;
        repeat (2) tick();

        // per FLL (addr 0x018 -> per, reg 2) write, ack one cycle after req
        set_lit(1, 4, 32'h12345678, 0, 2, 2'd2, 0, 32'hCAFE0001);
        do_xfer(12'h018, 1, 32'hCAFE0001, 32'h12345678, 1);
        lit_on = 0;
        // cluster read reg 1, immediate ack
        set_lit(2, 3, 32'hDEADBEAF, 0, 1, 2'd1, 1, 32'h0);
        do_xfer(12'h024, 0, 32'h0, 32'hDEADBEAF, 0);
        lit_on = 0;
        // soc never acks -> timeout after T cycles of req
        set_lit(0, 10, 32'h0, 1, 8, 2'd0, 1, 32'h0);
        do_xfer(12'h000, 0, 32'h0, 32'hAAAA5555, -1);
        lit_on = 0;
        // ack in the last allowed REQ cycle beats the timeout
        set_lit(0, 10, 32'h0BADF00D, 0, 8, 2'd3, 0, 32'h00000077);
        do_xfer(12'h00C, 1, 32'h00000077, 32'h0BADF00D, 7);
        lit_on = 0;
        // stray acks on the other FLLs during a soc transfer
        noise_en = 1;
        set_lit(0, 6, 32'h13572468, 0, 4, 2'd1, 1, 32'h0);
        do_xfer(12'h004, 0, 32'h0, 32'h13572468, 3);
        set_lit(0, 10, 32'h0, 1, 8, 2'd2, 0, 32'h00000042);
        do_xfer(12'h008, 1, 32'h00000042, 32'h11111111, -1);
        lit_on = 0; noise_en = 0;
        // lock status: soc=1 per=0 cluster=1 held, then status read and write
        lock_v = 3'b101;
        repeat (3) tick();
        set_lit(0, 1, 32'h5, 0, 0, 2'd0, 0, 32'h0);
        do_xfer(12'h030, 0, 32'h0, 32'h0, 0);
        set_lit(0, 1, 32'h0, 1, 0, 2'd0, 0, 32'h0);
        do_xfer(12'h030, 1, 32'hFFFF0000, 32'h0, 0);
        lit_on = 0;

        // randomized traffic
        lock_rand_en = 1;
        for (int i = 0; i < 60; i++) begin
            int d;
            case ($urandom_range(0, 4))
                0: d = 0;
                1: d = 1;
                2: d = T - 1;
                3: d = -1;
                default: d = int'($urandom_range(0, T + 1));
            endcase
            noise_en = bit'($urandom_range(0, 1));
            do_xfer(12'($urandom), bit'($urandom_range(0, 1)), $urandom, $urandom, d);
        end
        noise_en = 0; lock_rand_en = 0; lock_v = 3'b000;
        repeat (3) tick();

        // reset asserted while a soc read is in REQ
        tgt_mask = 3'b001; exp_rst_chk = 0;
        tick();
        paddr = 12'h004; pwdata = 32'h00000055; pwrite = 0; psel = 1; penable = 0;
        set_idle_exp();
        tick();
        penable = 1; acc_cycle = 1;
        for (int k = 2; k <= 3; k++) begin
            tick();
            acc_cycle = k; exp_req = 3'b001; exp_fll_chk = 1; exp_tgt = 2'd0;
            exp_wrn = 1; exp_add = 2'd1; exp_data = 32'h00000055;
        end
        #2;
        rst_ni = 0; psel = 0; penable = 0;
        set_idle_exp();
        exp_rst_chk = 1;
        repeat (2) tick();
        rst_ni = 1;
        tick();
        exp_rst_chk = 0;
        set_lit(0, 4, 32'h600DCAFE, 0, 2, 2'd3, 0, 32'h0000BEEF);
        do_xfer(12'h00C, 1, 32'h0000BEEF, 32'h600DCAFE, 1);
        lit_on = 0;
        repeat (2) tick();

        exp_chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
